// File: rtl/inst_encoder.sv
// RV32I field-to-machine-word encoder that streams encoded instructions into IMEM.
// Optional build macro: INST_ENCODER_RANGE_CHECK_EN (treat out-of-range immediates as illegal).
module inst_encoder #(
    parameter int unsigned IMEM_AW   = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opcode,
    input  logic [5:0]         in_alucode,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [4:0]         in_rd,
    input  logic [31:0]        in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               done,
    output logic               err,
    output logic [IMEM_AW-1:0] err_addr
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [5:0] ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3;
    localparam logic [5:0] ALU_BNE  = 6'd4;
    localparam logic [5:0] ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6;
    localparam logic [5:0] ALU_BLTU = 6'd7;
    localparam logic [5:0] ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9;
    localparam logic [5:0] ALU_LH   = 6'd10;
    localparam logic [5:0] ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12;
    localparam logic [5:0] ALU_LHU  = 6'd13;
    localparam logic [5:0] ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15;
    localparam logic [5:0] ALU_SW   = 6'd16;
    localparam logic [5:0] ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18;
    localparam logic [5:0] ALU_XOR  = 6'd19;
    localparam logic [5:0] ALU_OR   = 6'd20;
    localparam logic [5:0] ALU_AND  = 6'd21;
    localparam logic [5:0] ALU_SLL  = 6'd22;
    localparam logic [5:0] ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24;
    localparam logic [5:0] ALU_SLT  = 6'd25;
    localparam logic [5:0] ALU_SLTU = 6'd26;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [6:0]  F7_ALT   = 7'b0100000;

    typedef enum logic [1:0] {IDLE, WRITE, DONE, FULL} state_t;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    state_t             state_q, state_d;
    fmt_t               fmt;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               alu_ok;
    logic [31:0]        raw_word;
    logic [31:0]        enc_word_c;
    logic               enc_illegal_c;
    logic               last_q, last_d;
    logic               in_ready_d, imem_we_d, done_d, err_d;
    logic [IMEM_AW-1:0] imem_addr_d, err_addr_d;
    logic [31:0]        imem_wdata_d;

`ifdef INST_ENCODER_RANGE_CHECK_EN
    function automatic logic imm_fits(input fmt_t f, input logic [31:0] imm);
        case (f)
            FMT_I, FMT_S: imm_fits = (&imm[31:11]) | ~(|imm[31:11]);
            FMT_B:        imm_fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_J:        imm_fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            FMT_U:        imm_fits = ~(|imm[11:0]);
            FMT_SH:       imm_fits = ~(|imm[31:5]);
            default:      imm_fits = 1'b1;
        endcase
    endfunction
`endif

    // Classify opcode/alucode into a format plus funct fields and legality.
    always_comb begin
        fmt    = FMT_I;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        alu_ok = 1'b0;
        case (in_opcode)
            OPC_OPIMM, OPC_OP: begin
                alu_ok = 1'b1;
                case (in_alucode)
                    ALU_ADD:  funct3 = 3'b000;
                    ALU_SUB:  begin funct3 = 3'b000; funct7 = F7_ALT; alu_ok = (in_opcode == OPC_OP); end
                    ALU_SLL:  begin funct3 = 3'b001; fmt = FMT_SH; end
                    ALU_SLT:  funct3 = 3'b010;
                    ALU_SLTU: funct3 = 3'b011;
                    ALU_XOR:  funct3 = 3'b100;
                    ALU_SRL:  begin funct3 = 3'b101; fmt = FMT_SH; end
                    ALU_SRA:  begin funct3 = 3'b101; funct7 = F7_ALT; fmt = FMT_SH; end
                    ALU_OR:   funct3 = 3'b110;
                    ALU_AND:  funct3 = 3'b111;
                    default:  alu_ok = 1'b0;
                endcase
                if (in_opcode == OPC_OP) begin
                    fmt = FMT_R;
                end
            end
            OPC_LOAD: begin
                alu_ok = 1'b1;
                case (in_alucode)
                    ALU_LB:  funct3 = 3'b000;
                    ALU_LH:  funct3 = 3'b001;
                    ALU_LW:  funct3 = 3'b010;
                    ALU_LBU: funct3 = 3'b100;
                    ALU_LHU: funct3 = 3'b101;
                    default: alu_ok = 1'b0;
                endcase
            end
            OPC_JALR: alu_ok = (in_alucode == ALU_JALR);
            OPC_STORE: begin
                fmt    = FMT_S;
                alu_ok = 1'b1;
                case (in_alucode)
                    ALU_SB:  funct3 = 3'b000;
                    ALU_SH:  funct3 = 3'b001;
                    ALU_SW:  funct3 = 3'b010;
                    default: alu_ok = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                fmt    = FMT_B;
                alu_ok = 1'b1;
                case (in_alucode)
                    ALU_BEQ:  funct3 = 3'b000;
                    ALU_BNE:  funct3 = 3'b001;
                    ALU_BLT:  funct3 = 3'b100;
                    ALU_BGE:  funct3 = 3'b101;
                    ALU_BLTU: funct3 = 3'b110;
                    ALU_BGEU: funct3 = 3'b111;
                    default:  alu_ok = 1'b0;
                endcase
            end
            // U/J formats carry no funct field, so the ALU code is don't-care.
            OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; alu_ok = 1'b1; end
            OPC_JAL:            begin fmt = FMT_J; alu_ok = 1'b1; end
            default:            alu_ok = 1'b0;
        endcase
    end

    // Assemble the machine word for the selected format.
    always_comb begin
        raw_word = 32'h0000_0000;
        case (fmt)
            FMT_R:   raw_word = {funct7, in_rs2, in_rs1, funct3, in_rd, in_opcode};
            FMT_I:   raw_word = {in_imm[11:0], in_rs1, funct3, in_rd, in_opcode};
            FMT_SH:  raw_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, in_opcode};
            FMT_S:   raw_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], in_opcode};
            FMT_B:   raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
            FMT_U:   raw_word = {in_imm[31:12], in_rd, in_opcode};
            FMT_J:   raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
            default: raw_word = 32'h0000_0000;
        endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
        enc_illegal_c = ~alu_ok | ~imm_fits(fmt, in_imm);
`else
        enc_illegal_c = ~alu_ok;
`endif
        enc_word_c = enc_illegal_c ? NOP_WORD : raw_word;
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        in_ready_d   = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        done_d       = done;
        err_d        = err;
        err_addr_d   = err_addr;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d      = WRITE;
                    imem_we_d    = 1'b1;
                    imem_wdata_d = enc_word_c;
                    last_d       = in_last;
                    if (enc_illegal_c && !err) begin
                        err_d      = 1'b1;
                        err_addr_d = imem_addr;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            WRITE: begin
                if (!(&imem_addr)) begin
                    imem_addr_d = imem_addr + IMEM_AW'(1);
                end
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (&imem_addr) begin
                    state_d = FULL;
                end else begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                end
            end
            DONE: done_d = 1'b1;
            FULL: begin
                if (in_valid && !err) begin
                    err_d      = 1'b1;
                    err_addr_d = '1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= IMEM_AW'(BASE_ADDR);
            imem_wdata <= 32'h0000_0000;
            done       <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            in_ready   <= in_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            done       <= done_d;
            err        <= err_d;
            err_addr   <= err_addr_d;
        end
    end

endmodule
